// File: rtl/prog_loader_if.sv
// Purpose: bundles the loader's stream input, program-memory write port and status outputs.
// Latency: none, this is wiring only.
// Backpressure: InReady from the loader paces InValid/InData from the boot source.
interface prog_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic [15:0]           InData;
    logic                  InValid;
    logic                  InReady;
    logic [ADDR_WIDTH-1:0] MemAddr;
    logic [15:0]           MemWriteData;
    logic                  MemWrite;
    logic                  CPURst;
    logic                  LoadDone;
    logic                  LoadError;
    logic [ADDR_WIDTH:0]   WordCount;

    // Loader side.
    modport master (
        input  InData, InValid,
        output InReady, MemAddr, MemWriteData, MemWrite,
        output CPURst, LoadDone, LoadError, WordCount
    );

    // Boot source / memory / CPU side.
    modport slave (
        output InData, InValid,
        input  InReady, MemAddr, MemWriteData, MemWrite,
        input  CPURst, LoadDone, LoadError, WordCount
    );
endinterface

// File: rtl/prog_loader.sv
// Purpose: boot loader; takes a length/data/checksum frame, writes data words to program memory, then releases CPU reset.
// Latency: data accept at edge k -> MemWrite in cycle k+1; checksum accept at edge k -> CPURst low from cycle k+1.
// Backpressure: InReady drops for WRITE_CYCLES cycles after every data accept and stays low in RUN/ERROR.
module prog_loader #(
    parameter int ADDR_WIDTH   = 10,
    parameter int BASE_ADDR    = 0,
    parameter int WRITE_CYCLES = 1
) (
    input  logic          CLK,
    input  logic          Rst,
    prog_loader_if.master bus
);
    localparam int unsigned MAX_WORDS = 32'd1 << ADDR_WIDTH;
    localparam int LW = ADDR_WIDTH + 1;
    localparam int WW = $clog2(WRITE_CYCLES + 1);
    localparam int AW = ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CHECK,
        S_RUN,
        S_ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic [15:0]     sum_q, sum_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic            we_q, we_d;
    logic            in_ready;
    logic            accept;

    assign in_ready = ((state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHECK))
                      && (wait_q == '0);
    assign accept   = bus.InValid & in_ready;

    assign bus.InReady      = in_ready;
    assign bus.MemAddr      = addr_q;
    assign bus.MemWriteData = wdata_q;
    assign bus.MemWrite     = we_q;
    assign bus.CPURst       = (state_q != S_RUN);
    assign bus.LoadDone     = (state_q == S_RUN);
    assign bus.LoadError    = (state_q == S_ERROR);
    assign bus.WordCount    = cnt_q;

    // State and datapath registers; reset discards all load progress immediately.
    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            wait_q  <= '0;
            addr_q  <= AW'(BASE_ADDR);
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end

    // Frame parsing: next state, checksum accumulation, write strobe and recovery countdown.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        wait_d  = (wait_q != '0) ? wait_q - WW'(1) : wait_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_LEN;
            end
            S_LEN: begin
                if (accept) begin
                    len_d = LW'(bus.InData);
                    if (32'(bus.InData) > MAX_WORDS) begin
                        state_d = S_ERROR;
                    end else if (bus.InData == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = AW'(BASE_ADDR) + cnt_q[AW-1:0];
                    wdata_d = bus.InData;
                    sum_d   = sum_q + bus.InData;
                    cnt_d   = cnt_q + LW'(1);
                    wait_d  = WW'(WRITE_CYCLES);
                    if (cnt_q + LW'(1) == len_q) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (accept) begin
                    state_d = (bus.InData == sum_q) ? S_RUN : S_ERROR;
                end
            end
            S_RUN:   state_d = S_RUN;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase
    end
endmodule
